multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Multi-cycle successor to the single-cycle RV32I main decoder: an FSM that sequences
//  FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several cycles, sharing one ALU and one
//  unified memory port. It drives the datapath muxes and enables, handshakes with memory,
//  traps on illegal opcodes or memory timeout, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT   16  max cycles mem_req may wait for mem_ready before trapping (>=2)
//  SUPPORT_JALR  1   1: opcode 1100111 executes as JALR; 0: it is illegal
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk           in   1      clock, rising edge
//  reset_n       in   1      synchronous active-low reset
//  start         in   1      run enable; sampled in IDLE and at instruction end
//  opcode        in   7      instr[6:0] from the instruction register
//  mem_ready     in   1      memory accepted/completed the current mem_req
//  mem_req       out  1      memory access request
//  mem_we        out  1      write qualifier for mem_req
//  adr_src       out  1      0 = PC, 1 = ALUOut as memory address
//  ir_write      out  1      load IR (FETCH && mem_ready)
//  pc_write      out  1      unconditional PC update
//  branch        out  1      PC update if ALU zero (BEQ)
//  jump          out  1      jump cycle marker
//  alu_src_a     out  2      00 PC, 01 oldPC, 10 rs1
//  alu_src_b     out  2      00 rs2, 01 imm, 10 const 4
//  alu_op        out  2      00 add, 01 sub/compare, 10 funct-decoded
//  result_src    out  2      00 ALUOut, 01 mem data, 10 ALU result
//  reg_write     out  1      register file write enable
//  illegal_op    out  1      sticky: TRAP entered on bad opcode
//  mem_timeout   out  1      sticky: TRAP entered on memory timeout
//  state_o       out  4      current state encoding (debug)
//  retired       out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  - reset_n=0 at a clock edge: state<=IDLE, wait_cnt<=0, retired<=0, flags<=0, from any state
//    including mid-access. All outputs are 0 in IDLE; all outputs are Moore (state decode)
//    except ir_write/pc_write in FETCH, which are gated by mem_ready.
//  - States: IDLE=0 FETCH=1 DECODE=2 MEM_ADR=3 MEM_READ=4 MEM_WB=5 MEM_WRITE=6 EXEC_R=7
//    EXEC_I=8 ALU_WB=9 BRANCH=10 JUMP=11 JALR_ADR=12 TRAP=15.
//  - IDLE: start=1 -> FETCH. FETCH: mem_req, adr_src=0, a=00, b=10, op=00, result_src=10;
//    on mem_ready: ir_write=pc_write=1, -> DECODE.
//  - DECODE: a=01, b=01, op=00 (branch/JAL target to ALUOut). Next by opcode:
//    0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH;
//    1101111 -> JUMP; 1100111 -> JALR_ADR if SUPPORT_JALR else TRAP; any other -> TRAP, illegal_op=1.
//  - MEM_ADR: a=10, b=01, op=00; load -> MEM_READ, store -> MEM_WRITE.
//  - MEM_READ: mem_req, adr_src=1; on mem_ready -> MEM_WB. MEM_WB: result_src=01, reg_write.
//  - MEM_WRITE: mem_req, mem_we, adr_src=1; on mem_ready -> end.
//  - EXEC_R: a=10, b=00, op=10. EXEC_I: a=10, b=01, op=10. Both -> ALU_WB.
//  - ALU_WB: result_src=00, reg_write. BRANCH: a=10, b=00, op=01, result_src=00, branch=1.
//  - JALR_ADR: a=10, b=01, op=00 -> JUMP. JUMP: a=01, b=10, op=00, result_src=00,
//    pc_write=1, jump=1 -> ALU_WB (writes oldPC+4 to rd).
//  - End of instruction = leaving MEM_WB, MEM_WRITE(ready), ALU_WB, BRANCH: retired+=1
//    (wraps modulo 2^CNT_W); next is FETCH if start=1 else IDLE.
//  - Wait counter: counts cycles in a mem_req state with mem_ready=0, clears on state change.
//    When it reaches MEM_TIMEOUT-1 with mem_ready=0 -> TRAP, mem_timeout=1. mem_ready=1 on
//    that same cycle wins (normal advance, no trap).
//  - TRAP: all datapath outputs 0, flags held; exits only via reset_n.
// TESTING
//  - Reset: reset_n=0 in MEM_READ with mem_req=1 -> next edge state_o=0, all outputs 0, retired=0.
//  - R-type 0110011, mem_ready=1 in FETCH -> states 1,2,7,9,1; reg_write=1 only in ALU_WB; retired=1.
//  - Load 0000011, mem_ready delayed 3 cycles in MEM_READ -> mem_req held 4 cycles, then MEM_WB result_src=01.
//  - BEQ 1100011 then start=0 -> BRANCH branch=1, alu_op=01, then IDLE; retired increments.
//  - mem_ready stuck 0 in FETCH, MEM_TIMEOUT=16 -> TRAP after 16 cycles, mem_timeout=1;
//    ready=1 on 16th cycle -> DECODE instead.
//  - 1100111 with SUPPORT_JALR=0 -> TRAP, illegal_op=1; with 1 -> states 12,11,9; opcode 1111111 -> TRAP.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multi-cycle main controller and its datapath/memory.
// No logic: signal grouping only. The controller side uses 'master'.
// Handshake: mem_req is held until mem_ready; the datapath side supplies start/opcode/mem_ready.
interface multicycle_main_control_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             jump;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             reg_write;
    logic             illegal_op;
    logic             mem_timeout;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, opcode, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, result_src, reg_write,
               illegal_op, mem_timeout, state_o, retired
    );

    modport slave (
        output start, opcode, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, result_src, reg_write,
               illegal_op, mem_timeout, state_o, retired
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: one state per cycle; memory states stall until mem_ready or MEM_TIMEOUT cycles.
// Backpressure: mem_req held while mem_ready=0; timeout traps until reset_n.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit SUPPORT_JALR = 1'b1,
    parameter int CNT_W        = 32
) (
    input logic                       clk,
    input logic                       reset_n,
    multicycle_main_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JALR_ADR  = 4'd12,
        S_TRAP      = 4'd15
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       pc_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       reg_write;
    } ctl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_nxt;
    logic [CNT_W-1:0]   retired_q;
    logic               illegal_q;
    logic               timeout_q;
    ctl_t               ctl_q;
    logic               retire;
    logic               trap_ill;
    logic               trap_to;
    logic               in_mem;

    // Moore control word for a state; 'fetch' marks the cycles where ir/pc writes follow mem_ready.
    function automatic ctl_t ctl_decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JUMP: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
                c.jump      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

    // Next-state selection, end-of-instruction detection and memory wait/timeout tracking.
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = '0;
        retire    = 1'b0;
        trap_ill  = 1'b0;
        trap_to   = 1'b0;
        case (state_q)
            S_IDLE:     if (bus.start) state_nxt = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                    OP_RTYPE:          state_nxt = S_EXEC_R;
                    OP_ITYPE:          state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JUMP;
                    OP_JALR: begin
                        if (SUPPORT_JALR) begin
                            state_nxt = S_JALR_ADR;
                        end else begin
                            state_nxt = S_TRAP;
                            trap_ill  = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = S_TRAP;
                        trap_ill  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR:  state_nxt = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: if (bus.mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = bus.start ? S_FETCH : S_IDLE;
                end
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH: begin
                retire    = 1'b1;
                state_nxt = bus.start ? S_FETCH : S_IDLE;
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
            S_JALR_ADR:         state_nxt = S_JUMP;
            S_JUMP:             state_nxt = S_ALU_WB;
            S_TRAP:             state_nxt = S_TRAP;
            default:            state_nxt = S_TRAP;
        endcase
        // A ready on the last allowed cycle wins over the timeout.
        if (in_mem && !bus.mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                state_nxt = S_TRAP;
                trap_to   = 1'b1;
            end else begin
                wait_nxt = wait_q + WAIT_W'(1);
            end
        end
    end

    // State, counters, sticky flags and registered Moore control word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            ctl_q     <= '0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            ctl_q   <= ctl_decode(state_nxt);
            if (retire)   retired_q <= retired_q + CNT_W'(1);
            if (trap_ill) illegal_q <= 1'b1;
            if (trap_to)  timeout_q <= 1'b1;
        end
    end

    assign bus.mem_req     = ctl_q.mem_req;
    assign bus.mem_we      = ctl_q.mem_we;
    assign bus.adr_src     = ctl_q.adr_src;
    assign bus.ir_write    = ctl_q.fetch & bus.mem_ready;
    assign bus.pc_write    = ctl_q.pc_write | (ctl_q.fetch & bus.mem_ready);
    assign bus.branch      = ctl_q.branch;
    assign bus.jump        = ctl_q.jump;
    assign bus.alu_src_a   = ctl_q.alu_src_a;
    assign bus.alu_src_b   = ctl_q.alu_src_b;
    assign bus.alu_op      = ctl_q.alu_op;
    assign bus.result_src  = ctl_q.result_src;
    assign bus.reg_write   = ctl_q.reg_write;
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state_o     = state_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed vector table, corner sequences, random run.
// u0 is the default configuration; u1 disables JALR and has a 3-bit retire counter.
module tb_multicycle_main_control;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] opcode;
    logic       mem_ready;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    multicycle_main_control_if #(.CNT_W(32)) bus0 ();
    multicycle_main_control_if #(.CNT_W(3))  bus1 ();

    assign bus0.start     = start;
    assign bus0.opcode    = opcode;
    assign bus0.mem_ready = mem_ready;
    assign bus1.start     = start;
    assign bus1.opcode    = opcode;
    assign bus1.mem_ready = mem_ready;

    multicycle_main_control #(.MEM_TIMEOUT(TO), .SUPPORT_JALR(1'b1), .CNT_W(32)) u0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    multicycle_main_control #(.MEM_TIMEOUT(TO), .SUPPORT_JALR(1'b0), .CNT_W(3)) u1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    logic [15:0] dut_vec;
    assign dut_vec = {bus0.mem_req, bus0.mem_we, bus0.adr_src, bus0.ir_write, bus0.pc_write,
                      bus0.branch, bus0.jump, bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op,
                      bus0.result_src, bus0.reg_write};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an instruction is a list of phases chosen at decode; memory
    // phases linger until ready or until they have waited TO cycles.
    int          m_st = 0;
    int          m_q[$];
    int          m_wait = 0;
    int unsigned m_ret = 0;
    bit          m_ill = 0;
    bit          m_to = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin : model
        int nxt;
        bit adv;
        nxt = m_st;
        adv = 0;
        if (!reset_n) begin
            m_st = 0; m_q.delete(); m_wait = 0; m_ret = 0; m_ill = 0; m_to = 0;
        end else begin
            if (m_st == 0) begin
                if (start) nxt = 1;
            end else if (m_st == 1 || m_st == 4 || m_st == 6) begin
                if (mem_ready) begin
                    if (m_st == 1) nxt = 2;
                    else adv = 1;
                end else if (m_wait == TO - 1) begin
                    nxt = 15;
                    m_to = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_st == 2) begin
                case (opcode)
                    7'b0000011: m_q = '{3, 4, 5};
                    7'b0100011: m_q = '{3, 6};
                    7'b0110011: m_q = '{7, 9};
                    7'b0010011: m_q = '{8, 9};
                    7'b1100011: m_q = '{10};
                    7'b1101111: m_q = '{11, 9};
                    7'b1100111: m_q = '{12, 11, 9};
                    default:    m_q.delete();
                endcase
                if (m_q.size() == 0) begin
                    nxt = 15;
                    m_ill = 1;
                end else begin
                    nxt = m_q.pop_front();
                end
            end else if (m_st != 15) begin
                adv = 1;
            end
            if (adv) begin
                if (m_q.size() > 0) begin
                    nxt = m_q.pop_front();
                end else begin
                    m_ret++;
                    nxt = start ? 1 : 0;
                end
            end
            if (nxt != m_st) m_wait = 0;
            m_st = nxt;
        end
    end

    // Expected control outputs per phase, straight from the phase descriptions.
    function automatic logic [15:0] exp_vec(input int st, input logic rdy);
        logic mr, we, ad, ir, pc, br, jp, rw;
        logic [1:0] a, b, op, rs;
        {mr, we, ad, ir, pc, br, jp, rw} = '0;
        {a, b, op, rs} = '0;
        case (st)
            1:  begin mr = 1; ir = rdy; pc = rdy; b = 2'b10; rs = 2'b10; end
            2:  begin a = 2'b01; b = 2'b01; end
            3:  begin a = 2'b10; b = 2'b01; end
            4:  begin mr = 1; ad = 1; end
            5:  begin rs = 2'b01; rw = 1; end
            6:  begin mr = 1; we = 1; ad = 1; end
            7:  begin a = 2'b10; op = 2'b10; end
            8:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            9:  begin rw = 1; end
            10: begin a = 2'b10; op = 2'b01; br = 1; end
            11: begin a = 2'b01; b = 2'b10; pc = 1; jp = 1; end
            12: begin a = 2'b10; b = 2'b01; end
            default: ;
        endcase
        return {mr, we, ad, ir, pc, br, jp, a, b, op, rs, rw};
    endfunction

    // Continuous comparison of u0 against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", 64'(bus0.state_o), 64'(m_st));
            check("model_outs", 64'(dut_vec), 64'(exp_vec(m_st, mem_ready)));
            check("model_cnt_flags", {30'd0, bus0.illegal_op, bus0.mem_timeout, bus0.retired},
                  {30'd0, m_ill, m_to, m_ret});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        cyc(2);
        reset_n   = 1'b1;
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] ops [7];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111};
        if ($urandom_range(0, 9) == 0) return 7'($urandom_range(0, 127));
        return ops[$urandom_range(0, 6)];
    endfunction

    typedef struct packed {
        logic [6:0]  op;
        logic [3:0]  n;
        logic [31:0] seq;   // one hex digit per cycle, first state leftmost
        logic [7:0]  ret;
        logic        ill;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int thr;
        logic [3:0] exp_st;

        tbl[0] = '{op: 7'b0110011, n: 4'd6, seq: 32'h012791,  ret: 8'd1, ill: 1'b0};
        tbl[1] = '{op: 7'b0010011, n: 4'd6, seq: 32'h012891,  ret: 8'd1, ill: 1'b0};
        tbl[2] = '{op: 7'b0000011, n: 4'd7, seq: 32'h0123451, ret: 8'd1, ill: 1'b0};
        tbl[3] = '{op: 7'b0100011, n: 4'd6, seq: 32'h012361,  ret: 8'd1, ill: 1'b0};
        tbl[4] = '{op: 7'b1100011, n: 4'd5, seq: 32'h012a1,   ret: 8'd1, ill: 1'b0};
        tbl[5] = '{op: 7'b1101111, n: 4'd6, seq: 32'h012b91,  ret: 8'd1, ill: 1'b0};
        tbl[6] = '{op: 7'b1100111, n: 4'd7, seq: 32'h012cb91, ret: 8'd1, ill: 1'b0};
        tbl[7] = '{op: 7'b1111111, n: 4'd5, seq: 32'h012ff,   ret: 8'd0, ill: 1'b1};
        tbl[8] = '{op: 7'b0000000, n: 4'd5, seq: 32'h012ff,   ret: 8'd0, ill: 1'b1};

        opcode = 7'b0110011;
        do_reset();
        chk_en = 1;

        // Table: state sequence per opcode with ready always high and start held.
        for (int k = 0; k < 9; k++) begin
            do_reset();
            exp_st = tbl[k].seq[(int'(tbl[k].n) - 1) * 4 +: 4];
            check("tbl_reset_state", 64'(bus0.state_o), 64'(exp_st));
            check("tbl_reset_outs", 64'(dut_vec), 64'd0);
            start = 1'b1; mem_ready = 1'b1; opcode = tbl[k].op;
            for (int i = 1; i < int'(tbl[k].n); i++) begin
                cyc(1);
                exp_st = tbl[k].seq[(int'(tbl[k].n) - 1 - i) * 4 +: 4];
                check("tbl_state", 64'(bus0.state_o), 64'(exp_st));
                check("tbl_reg_write", 64'(bus0.reg_write),
                      64'((exp_st == 4'd9) || (exp_st == 4'd5)));
            end
            check("tbl_retired", 64'(bus0.retired), 64'(tbl[k].ret));
            check("tbl_illegal", 64'(bus0.illegal_op), 64'(tbl[k].ill));
            if (tbl[k].op == 7'b1100111) begin
                check("nojalr_state", 64'(bus1.state_o), 64'd15);
                check("nojalr_illegal", 64'(bus1.illegal_op), 64'd1);
            end
        end

        // Reset in the middle of a load's memory read.
        do_reset();
        start = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        cyc(5);
        opcode = 7'b0000011;
        cyc(2);
        mem_ready = 1'b0;
        cyc(1);
        check("midrd_state", 64'(bus0.state_o), 64'd4);
        check("midrd_mem_req", 64'(bus0.mem_req), 64'd1);
        check("midrd_retired", 64'(bus0.retired), 64'd1);
        reset_n = 1'b0;
        cyc(1);
        check("rst_state", 64'(bus0.state_o), 64'd0);
        check("rst_outs", 64'(dut_vec), 64'd0);
        check("rst_retired", 64'(bus0.retired), 64'd0);
        reset_n = 1'b1;

        // Load with three not-ready cycles in MEM_READ.
        do_reset();
        start = 1'b1; mem_ready = 1'b1; opcode = 7'b0000011;
        cyc(2);
        mem_ready = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            check("ld_wait_state", 64'(bus0.state_o), 64'd4);
            check("ld_wait_mem_req", 64'(bus0.mem_req), 64'd1);
            if (i == 3) mem_ready = 1'b1;
            cyc(1);
        end
        check("ld_wb_state", 64'(bus0.state_o), 64'd5);
        check("ld_wb_result_src", 64'(bus0.result_src), 64'd1);
        check("ld_wb_reg_write", 64'(bus0.reg_write), 64'd1);
        check("ld_wb_mem_req", 64'(bus0.mem_req), 64'd0);

        // Branch, then start drops so the controller parks in IDLE.
        do_reset();
        start = 1'b1; mem_ready = 1'b1; opcode = 7'b1100011;
        cyc(2);
        start = 1'b0;
        cyc(1);
        check("beq_state", 64'(bus0.state_o), 64'd10);
        check("beq_branch", 64'(bus0.branch), 64'd1);
        check("beq_alu_op", 64'(bus0.alu_op), 64'd1);
        cyc(1);
        check("beq_idle", 64'(bus0.state_o), 64'd0);
        check("beq_retired", 64'(bus0.retired), 64'd1);

        // Fetch never acknowledged: sixteen FETCH cycles, then a sticky trap.
        do_reset();
        start = 1'b1; mem_ready = 1'b0; opcode = 7'b0110011;
        cyc(16);
        check("to_last_fetch", 64'(bus0.state_o), 64'd1);
        cyc(1);
        check("to_trap_state", 64'(bus0.state_o), 64'd15);
        check("to_flag", 64'(bus0.mem_timeout), 64'd1);
        check("to_illegal_clear", 64'(bus0.illegal_op), 64'd0);
        mem_ready = 1'b1;
        cyc(3);
        check("to_trap_held", 64'(bus0.state_o), 64'd15);

        // Ready arriving on the sixteenth FETCH cycle beats the timeout.
        do_reset();
        start = 1'b1; mem_ready = 1'b0; opcode = 7'b0110011;
        cyc(16);
        mem_ready = 1'b1;
        #1;
        check("late_rdy_ir_write", 64'(bus0.ir_write), 64'd1);
        cyc(1);
        check("late_rdy_decode", 64'(bus0.state_o), 64'd2);
        check("late_rdy_no_to", 64'(bus0.mem_timeout), 64'd0);

        // Nine back-to-back R-type instructions: 3-bit counter wraps.
        do_reset();
        start = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        cyc(37);
        check("wrap_cnt32", 64'(bus0.retired), 64'd9);
        check("wrap_cnt3", 64'(bus1.retired), 64'd1);

        // Random traffic against the model; opcode only changes before decode.
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       thr = 95;
                1:       thr = 60;
                default: thr = 5;
            endcase
            for (int c = 0; c < 250; c++) begin
                reset_n   = !((m_st == 15) || ($urandom_range(0, 199) == 0));
                start     = ($urandom_range(0, 9) != 0);
                mem_ready = ($urandom_range(0, 99) < thr);
                if (m_st <= 1) opcode = pick_op();
                cyc(1);
            end
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
